// File: rtl/lib_sched_pkg.sv
// Shared types for the iSLIP scheduler and its helpers.
package lib_sched_pkg;

  // Schedule controller states: wait for start, iterate, publish result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/lib_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod W.
module lib_rr_pick #(
  parameter int W  = 4,
  parameter int PW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [W-1:0]  grant,
  output logic          grant_valid
);

  logic [PW-1:0] idx;

  // Scan W positions starting at ptr; the first hit wins and blocks the rest.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 0; i < W; i++) begin
      idx = PW'((int'(ptr) + i) % W);
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lib_islip_scheduler.sv
// Multi-iteration iSLIP scheduler: request/grant/accept, one iteration per clock.
// Grant and accept pointers persist across schedules and only move on first-iteration accepts.
module lib_islip_scheduler
  import lib_sched_pkg::*;
#(
  parameter int N    = 4,
  parameter int M    = 4,
  parameter int ITER = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [N-1:0][M-1:0]   i_request,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [M-1:0][N-1:0]   o_match,
  output logic [N-1:0]          o_input_matched
);

  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = $clog2(ITER + 1);

  sched_state_t             state_reg;
  logic [CW-1:0]            cnt_reg;
  logic [N-1:0][M-1:0]      req_reg;
  logic [M-1:0][N-1:0]      match_reg;
  logic [N-1:0]             in_matched_reg;
  logic [M-1:0][NW-1:0]     g_ptr_reg;
  logic [N-1:0][MW-1:0]     a_ptr_reg;
  logic                     valid_reg;

  logic [M-1:0]             out_matched;
  logic [M-1:0][N-1:0]      gnt_req;
  logic [M-1:0][N-1:0]      grant;
  logic [M-1:0]             grant_any;
  logic [N-1:0][M-1:0]      acc_req;
  logic [N-1:0][M-1:0]      accept;
  logic [N-1:0]             acc_valid;
  logic [M-1:0][N-1:0]      match_new;
  logic [M-1:0][NW-1:0]     g_ptr_next;
  logic [N-1:0][MW-1:0]     a_ptr_next;
  logic                     any_accept;
  logic                     last_iter;

  genvar gi, gj;

  // Grant stage: one picker per output over the unmatched inputs still requesting it.
  generate
    for (gi = 0; gi < M; gi++) begin : g_grant
      assign out_matched[gi] = |match_reg[gi];
      for (gj = 0; gj < N; gj++) begin : g_req
        assign gnt_req[gi][gj] = req_reg[gj][gi] & ~in_matched_reg[gj] & ~out_matched[gi];
      end
      lib_rr_pick #(.W(N), .PW(NW)) u_grant (
        .req         (gnt_req[gi]),
        .ptr         (g_ptr_reg[gi]),
        .grant       (grant[gi]),
        .grant_valid (grant_any[gi])
      );
    end
  endgenerate

  // Accept stage: one picker per input over the outputs that granted it.
  generate
    for (gi = 0; gi < N; gi++) begin : g_accept
      for (gj = 0; gj < M; gj++) begin : g_acc
        assign acc_req[gi][gj]   = grant[gj][gi] & grant_any[gj];
        assign match_new[gj][gi] = accept[gi][gj];
      end
      lib_rr_pick #(.W(M), .PW(MW)) u_accept (
        .req         (acc_req[gi]),
        .ptr         (a_ptr_reg[gi]),
        .grant       (accept[gi]),
        .grant_valid (acc_valid[gi])
      );
    end
  endgenerate

  assign any_accept = |acc_valid;
  assign last_iter  = (int'(cnt_reg) + 1 == ITER);

  // Pointers advance one past the partner of each accepted pair; others hold.
  always_comb begin
    g_ptr_next = g_ptr_reg;
    a_ptr_next = a_ptr_reg;
    for (int n = 0; n < N; n++) begin
      for (int m = 0; m < M; m++) begin
        if (accept[n][m]) begin
          g_ptr_next[m] = NW'((n + 1) % N);
          a_ptr_next[n] = MW'((m + 1) % M);
        end
      end
    end
  end

  // Schedule controller: latch requests, iterate until no progress or budget spent.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      req_reg        <= '0;
      match_reg      <= '0;
      in_matched_reg <= '0;
      g_ptr_reg      <= '0;
      a_ptr_reg      <= '0;
      valid_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          valid_reg <= 1'b0;
          if (i_start) begin
            req_reg        <= i_request;
            match_reg      <= '0;
            in_matched_reg <= '0;
            cnt_reg        <= '0;
            state_reg      <= ST_ITER;
          end
        end
        ST_ITER: begin
          match_reg      <= match_reg | match_new;
          in_matched_reg <= in_matched_reg | acc_valid;
          cnt_reg        <= cnt_reg + 1'b1;
          if (cnt_reg == '0) begin
            g_ptr_reg <= g_ptr_next;
            a_ptr_reg <= a_ptr_next;
          end
          if (!any_accept || last_iter) begin
            state_reg <= ST_DONE;
            valid_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          valid_reg <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy          = (state_reg == ST_ITER);
  assign o_valid         = valid_reg;
  assign o_match         = match_reg;
  assign o_input_matched = in_matched_reg;

endmodule
